// File: rtl/regfile_write_sched_if.sv
// Writeback request bus for the register-file write scheduler.
// Carries two independent valid/ready requesters (A and B), each with a
// destination select and write data.
//   master : writeback source side (drives valid/addr/data, sees ready)
//   slave  : scheduler side (sees valid/addr/data, drives ready)
interface regfile_write_sched_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4
);
    logic              a_valid;
    logic              a_ready;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  a_ready, b_ready
    );

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output a_ready, b_ready
    );
endinterface

// File: rtl/regfile_write_sched.sv
// Write-port scheduler for the register file. After reset it zeroes every
// register in address order, then shares the single write port between two
// writeback requesters with round-robin arbitration.
//   clk        : clock, rising edge
//   reset      : asynchronous active-low reset
//   wb         : requester A/B valid/ready bus (ready is combinational)
//   rf_ld      : register-file load enable, registered
//   rf_addr    : register-file destination select, registered
//   rf_data    : register-file write data, registered
//   init_done  : high once the zero sweep has issued every address
//   last_grant : last accepted requester (0 = A, 1 = B)
module regfile_write_sched #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    regfile_write_sched_if.slave    wb,
    output logic                    rf_ld,
    output logic [ADDR_W-1:0]       rf_addr,
    output logic [DATA_W-1:0]       rf_data,
    output logic                    init_done,
    output logic                    last_grant
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] cnt, cnt_nx;
    logic              rf_ld_nx;
    logic [ADDR_W-1:0] rf_addr_nx;
    logic [DATA_W-1:0] rf_data_nx;
    logic              init_done_nx;
    logic              last_grant_nx;
    logic              grant_a;
    logic              grant_b;

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= INIT;
            cnt        <= '0;
            rf_ld      <= 1'b0;
            rf_addr    <= '0;
            rf_data    <= '0;
            init_done  <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            rf_ld      <= rf_ld_nx;
            rf_addr    <= rf_addr_nx;
            rf_data    <= rf_data_nx;
            init_done  <= init_done_nx;
            last_grant <= last_grant_nx;
        end
    end

    // Round-robin grant and next-state logic; on a tie the requester that
    // did not win last time goes first.
    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        rf_ld_nx      = 1'b0;
        rf_addr_nx    = rf_addr;
        rf_data_nx    = rf_data;
        init_done_nx  = init_done;
        last_grant_nx = last_grant;
        grant_a       = wb.a_valid && (!wb.b_valid ||  last_grant);
        grant_b       = wb.b_valid && (!wb.a_valid || !last_grant);
        wb.a_ready    = 1'b0;
        wb.b_ready    = 1'b0;

        case (state)
            INIT: begin
                rf_ld_nx   = 1'b1;
                rf_addr_nx = cnt;
                rf_data_nx = '0;
                cnt_nx     = cnt + ADDR_W'(1);
                if (cnt == LAST_ADDR) begin
                    state_nx     = RUN;
                    init_done_nx = 1'b1;
                end
            end
            RUN: begin
                wb.a_ready = grant_a;
                wb.b_ready = grant_b;
                if (grant_a) begin
                    rf_ld_nx      = 1'b1;
                    rf_addr_nx    = wb.a_addr;
                    rf_data_nx    = wb.a_data;
                    last_grant_nx = 1'b0;
                end else if (grant_b) begin
                    rf_ld_nx      = 1'b1;
                    rf_addr_nx    = wb.b_addr;
                    rf_data_nx    = wb.b_data;
                    last_grant_nx = 1'b1;
                end
            end
            default: state_nx = INIT;
        endcase
    end

endmodule

// File: tb/tb_regfile_write_sched.sv
// Directed self-checking bench for regfile_write_sched.
module tb_regfile_write_sched;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 4;

    logic              clk;
    logic              reset;
    logic              rf_ld;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_data;
    logic              init_done;
    logic              last_grant;

    int checks = 0;
    int errors = 0;

    regfile_write_sched_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) wb ();

    regfile_write_sched #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .wb         (wb.slave),
        .rf_ld      (rf_ld),
        .rf_addr    (rf_addr),
        .rf_data    (rf_data),
        .init_done  (init_done),
        .last_grant (last_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Follow n sweep cycles starting right after reset release.
    task automatic sweep_check(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk($sformatf("sweep_ld[%0d]", i), 32'(rf_ld), 32'd1);
            chk($sformatf("sweep_addr[%0d]", i), 32'(rf_addr), 32'(i));
            chk($sformatf("sweep_data[%0d]", i), rf_data, 32'd0);
            chk($sformatf("sweep_done[%0d]", i), 32'(init_done), (i == 15) ? 32'd1 : 32'd0);
            if (i < 15) begin
                chk($sformatf("sweep_a_ready[%0d]", i), 32'(wb.a_ready), 32'd0);
                chk($sformatf("sweep_b_ready[%0d]", i), 32'(wb.b_ready), 32'd0);
            end
        end
    endtask

    initial begin
        reset      = 1'b0;
        wb.a_valid = 1'b0;
        wb.a_addr  = '0;
        wb.a_data  = '0;
        wb.b_valid = 1'b0;
        wb.b_addr  = '0;
        wb.b_data  = '0;

        // Reset state.
        tick();
        tick();
        chk("rst_ld", 32'(rf_ld), 32'd0);
        chk("rst_addr", 32'(rf_addr), 32'd0);
        chk("rst_data", rf_data, 32'd0);
        chk("rst_done", 32'(init_done), 32'd0);
        chk("rst_last_grant", 32'(last_grant), 32'd1);

        // Full sweep with idle requesters.
        @(negedge clk);
        reset = 1'b1;
        sweep_check(16);
        tick();
        chk("post_sweep_ld", 32'(rf_ld), 32'd0);
        chk("post_sweep_addr_hold", 32'(rf_addr), 32'd15);
        chk("post_sweep_done", 32'(init_done), 32'd1);

        // Single A write.
        wb.a_valid = 1'b1;
        wb.a_addr  = 4'd3;
        wb.a_data  = 32'hDEADBEEF;
        #1;
        chk("a_only_a_ready", 32'(wb.a_ready), 32'd1);
        chk("a_only_b_ready", 32'(wb.b_ready), 32'd0);
        tick();
        wb.a_valid = 1'b0;
        chk("a_only_ld", 32'(rf_ld), 32'd1);
        chk("a_only_addr", 32'(rf_addr), 32'd3);
        chk("a_only_data", rf_data, 32'hDEADBEEF);
        chk("a_only_last_grant", 32'(last_grant), 32'd0);
        tick();
        chk("a_only_idle_ld", 32'(rf_ld), 32'd0);
        chk("a_only_idle_data_hold", rf_data, 32'hDEADBEEF);

        // B write presented, then reset lands before the edge captures it.
        wb.b_valid = 1'b1;
        wb.b_addr  = 4'd9;
        wb.b_data  = 32'h99;
        #1;
        chk("b_pre_b_ready", 32'(wb.b_ready), 32'd1);
        chk("b_pre_a_ready", 32'(wb.a_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("b_rst_ld", 32'(rf_ld), 32'd0);
        chk("b_rst_addr", 32'(rf_addr), 32'd0);
        chk("b_rst_data", rf_data, 32'd0);
        chk("b_rst_done", 32'(init_done), 32'd0);
        chk("b_rst_last_grant", 32'(last_grant), 32'd1);
        chk("b_rst_b_ready", 32'(wb.b_ready), 32'd0);
        wb.b_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // Sweep up to address 7, then a one-cycle reset pulse.
        sweep_check(8);
        reset = 1'b0;
        #1;
        chk("mid_rst_ld", 32'(rf_ld), 32'd0);
        chk("mid_rst_addr", 32'(rf_addr), 32'd0);
        chk("mid_rst_done", 32'(init_done), 32'd0);
        chk("mid_rst_last_grant", 32'(last_grant), 32'd1);

        // A held valid through the whole restarted sweep.
        wb.a_valid = 1'b1;
        wb.a_addr  = 4'd5;
        wb.a_data  = 32'h55;
        @(negedge clk);
        reset = 1'b1;
        sweep_check(16);
        chk("held_last_grant", 32'(last_grant), 32'd1);
        chk("held_a_ready", 32'(wb.a_ready), 32'd1);
        chk("held_b_ready", 32'(wb.b_ready), 32'd0);
        tick();
        wb.a_valid = 1'b0;
        chk("held_ld", 32'(rf_ld), 32'd1);
        chk("held_addr", 32'(rf_addr), 32'd5);
        chk("held_data", rf_data, 32'h55);
        chk("held_last_grant_a", 32'(last_grant), 32'd0);

        // Continuous contention from the reset value of last_grant.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        sweep_check(16);
        wb.a_valid = 1'b1;
        wb.a_addr  = 4'd1;
        wb.a_data  = 32'h11;
        wb.b_valid = 1'b1;
        wb.b_addr  = 4'd2;
        wb.b_data  = 32'h22;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("rr_a_ready[%0d]", k), 32'(wb.a_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("rr_b_ready[%0d]", k), 32'(wb.b_ready), (k % 2 == 1) ? 32'd1 : 32'd0);
            tick();
            chk($sformatf("rr_ld[%0d]", k), 32'(rf_ld), 32'd1);
            chk($sformatf("rr_addr[%0d]", k), 32'(rf_addr), (k % 2 == 0) ? 32'd1 : 32'd2);
            chk($sformatf("rr_data[%0d]", k), rf_data, (k % 2 == 0) ? 32'h11 : 32'h22);
            chk($sformatf("rr_last_grant[%0d]", k), 32'(last_grant), 32'(k % 2));
        end
        wb.a_valid = 1'b0;
        wb.b_valid = 1'b0;
        tick();
        chk("rr_idle_ld", 32'(rf_ld), 32'd0);
        chk("rr_idle_addr_hold", 32'(rf_addr), 32'd2);
        chk("rr_idle_last_grant", 32'(last_grant), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_write_sched.md
# regfile_write_sched

Write-port scheduler for the 16 x 32-bit register file. It shares the file's single write port (load enable, 4-bit destination select, 32-bit data) between two writeback requesters, A and B, using valid/ready handshakes and round-robin arbitration. After every reset it first runs an init sequence that writes zero to all 16 registers. It sits between the writeback sources and the register-file decoder and data inputs; the read muxes are not affected.

## Interface
- DATA_W, 32, data width of a register
- ADDR_W, 4, destination select width; the file holds 2**ADDR_W registers
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low; low forces the reset state immediately
- a_valid  in  1  requester A has a write pending
- a_ready  out  1  A's write is accepted this cycle
- a_addr  in  ADDR_W  A destination register
- a_data  in  DATA_W  A write data
- b_valid, b_ready, b_addr, b_data  same as A, for requester B
- rf_ld  out  1  register-file load enable, registered
- rf_addr  out  ADDR_W  register-file destination select, registered
- rf_data  out  DATA_W  register-file write data, registered
- init_done  out  1  high once the zero sweep is complete
- last_grant  out  1  last accepted requester: 0 = A, 1 = B

## Operation
- Two states.
  - INIT: the zero sweep.
  - RUN: arbitrated writes.
- Reset (reset low):
  - State = INIT, sweep counter = 0.
  - rf_ld = 0, rf_addr = 0, rf_data = 0.
  - init_done = 0, last_grant = 1, so A wins the first tie.
- INIT:
  - On each edge: rf_ld = 1, rf_addr = counter, rf_data = 0, then counter + 1.
  - On the edge that issues address 2**ADDR_W - 1: counter wraps to 0, state becomes RUN, init_done becomes 1.
  - a_ready and b_ready are 0 for the whole of INIT.
- RUN grant logic (combinational, from current inputs):
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: grant the requester that is not last_grant.
  - Neither valid: no grant.
- a_ready = RUN and A granted; b_ready = RUN and B granted. At most one ready is high in any cycle.
- A transfer happens when valid and ready are both high at a rising edge. On that edge:
  - rf_ld = 1.
  - rf_addr and rf_data take the granted requester's addr and data.
  - last_grant is updated to the granted requester.
- Edge with no transfer: rf_ld = 0; rf_addr, rf_data and last_grant hold.
- Requester rules:
  - Hold valid, addr and data stable until ready is seen.
  - Ready may depend on the other requester's valid.
  - Valid must not depend on ready.
- No address-conflict logic. Two same-address writes on consecutive cycles both reach the file in grant order; the later one wins.

## Timing
- Reset to first sweep write: rf_ld is high starting from the first edge after reset deasserts. It stays high for exactly 2**ADDR_W cycles (16 by default), with addresses 0..15 in order.
- init_done rises on the same edge that presents address 15; RUN is entered at that edge. Ready can be high in the cycle that follows.
- Write latency: a transfer at edge N puts rf_ld/rf_addr/rf_data on the outputs from edge N until edge N+1. The register file captures the value during that cycle.
- Throughput: one write per cycle. Under continuous contention the grants alternate A, B, A, B.
- Reset asserted mid-operation:
  - Every output returns to its reset value asynchronously.
  - A write presented but not yet captured is lost.
  - The sweep restarts from address 0 once reset is released.
- Outputs are glitch-free registers. a_ready and b_ready are combinational from the valids, the state and last_grant.

## Test plan
- Release reset and hold both valids low: rf_ld is high for 16 cycles with rf_addr = 0..15 and rf_data = 0, init_done rises with address 15, then rf_ld = 0.
- After init, A only (a_addr = 3, a_data = 0xDEADBEEF, one cycle): a_ready = 1, then next cycle rf_ld = 1, rf_addr = 3, rf_data = 0xDEADBEEF, last_grant = 0; b_ready stays 0.
- Both valid continuously (A addr 1 data 0x11, B addr 2 data 0x22), starting from reset last_grant: the rf_addr sequence is 1, 2, 1, 2 with rf_ld high every cycle, and each ready is high on alternate cycles.
- Requests held valid during INIT (A addr 5 data 0x55): ready stays 0 for all 16 sweep cycles; the first RUN cycle gives a_ready = 1, and rf_addr = 5, rf_data = 0x55 appear the following cycle.
- Drop reset low for one cycle while the sweep is at address 7: outputs clear immediately, init_done = 0, and the sweep restarts at 0 and runs a full 16 writes.
- Drop reset low during a RUN transfer cycle (B addr 9): the rf_ld pulse for address 9 is never produced; the sweep runs, and last_grant = 1.
